// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin
//  Description : Sequential BCD-to-binary converter (reverse double dabble).
//                Each iteration shifts {bcd, acc} right by one bit, then
//                subtracts 3 from every BCD digit that is 8 or more. After
//                4*DIGITS iterations acc holds the binary value.
//                Start/done handshake: en (sampled in IDLE) / rdy (1 cycle).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters  : DIGITS    number of BCD digits on bcd_d_in (default 4)
//                BIN_W     width of bin_d_out (default 12)
//  Ports       : clk        system clock, rising edge
//                rst_n      synchronous active-low reset
//                en         start strobe, sampled only in IDLE
//                bcd_d_in   packed BCD input, digit 0 in [3:0]
//                bin_d_out  converted binary (low BIN_W bits of result)
//                rdy        one-cycle done pulse, outputs valid from it
//                ovf        result does not fit in BIN_W bits
//                err        input held a nibble > 9 (checking build only)
//  Macro       : BCD2BIN_CHECK_EN  when defined, invalid digits are detected
//                in SETUP and reported through err with an immediate DONE.
//                When undefined, err is tied to 0.
// ============================================================================
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_d_in,
  output logic [BIN_W-1:0]      bin_d_out,
  output logic                  rdy,
  output logic                  ovf,
  output logic                  err
);

  localparam int              ACC_W    = 4 * DIGITS;
  localparam int              CNT_W    = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SHIFT  = 3'd2,
    S_ADJUST = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ACC_W-1:0]    bcd_r;
  logic [ACC_W-1:0]    acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [ACC_W-1:0]    bcd_adj;
  logic [BIN_W-1:0]    acc_res;
  logic                acc_ovf;

  // A digit is >= 8 exactly when its MSB is set, so the compare is one bit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign bcd_adj[4*g +: 4] = bcd_r[4*g+3] ? (bcd_r[4*g +: 4] - 4'd3)
                                            : bcd_r[4*g +: 4];
  end

  if (BIN_W >= ACC_W) begin : g_res_wide
    assign acc_res = BIN_W'(acc_r);
    assign acc_ovf = 1'b0;
  end else begin : g_res_narrow
    assign acc_res = acc_r[BIN_W-1:0];
    assign acc_ovf = |acc_r[ACC_W-1:BIN_W];
  end

`ifdef BCD2BIN_CHECK_EN
  logic bad_digit;
  logic err_r;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_d_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (en) state_nxt = S_SETUP;
`ifdef BCD2BIN_CHECK_EN
      S_SETUP:  state_nxt = bad_digit ? S_DONE : S_SHIFT;
`else
      S_SETUP:  state_nxt = S_SHIFT;
`endif
      S_SHIFT:  state_nxt = S_ADJUST;
      S_ADJUST: state_nxt = (cnt_r == LAST_CNT) ? S_DONE : S_SHIFT;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign rdy = (state == S_DONE);

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_r     <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      bin_d_out <= '0;
      ovf       <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
      err_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_SETUP: begin
          bcd_r <= bcd_d_in;
          acc_r <= '0;
          cnt_r <= '0;
`ifdef BCD2BIN_CHECK_EN
          err_r <= bad_digit;
          if (bad_digit) begin
            bin_d_out <= '0;
            ovf       <= 1'b0;
          end
`endif
        end
        S_SHIFT: begin
          {bcd_r, acc_r} <= {bcd_r, acc_r} >> 1;
        end
        S_ADJUST: begin
          bcd_r <= bcd_adj;
          cnt_r <= cnt_r + CNT_W'(1);
          // acc is already final after the last shift; latch it on the
          // edge that enters DONE.
          if (cnt_r == LAST_CNT) begin
            bin_d_out <= acc_res;
            ovf       <= acc_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin
//  Description : Self-checking bench for bcd_to_bin (DIGITS=4, BIN_W=12).
//                Expected results come from decimal arithmetic on the BCD
//                digits; a binary-to-BCD function stands in for BCDConvert.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] bcd_d_in;
  logic [11:0] bin_d_out;
  logic        rdy;
  logic        ovf;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(4), .BIN_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int bcd_value(input logic [15:0] v);
    int s = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      s += int'(v[4*i +: 4]) * w;
      w *= 10;
    end
    return s;
  endfunction

  function automatic bit bcd_valid(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] bin_to_bcd(input int b);
    logic [15:0] v;
    int t = b;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Returns just after edge k, the edge that samples en.
  task automatic start(input logic [15:0] v);
    @(negedge clk);
    bcd_d_in = v;
    en       = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  // lat = n when rdy is seen high just before edge k+n; -1 if never.
  task automatic wait_rdy(output int lat);
    int n = 1;
    lat = -1;
    while (n <= 60) begin
      @(negedge clk);
      if (rdy) begin
        lat = n;
        break;
      end
      @(posedge clk);
      n++;
      if (n == 3) bcd_d_in = 16'($urandom);  // input moves after capture
    end
  endtask

  task automatic run_one(input logic [15:0] v, input string tag);
    int lat;
    int val;
    bit ok;
    int exp_lat;
    val = bcd_value(v);
    ok  = bcd_valid(v);
`ifdef BCD2BIN_CHECK_EN
    exp_lat = ok ? 2 + 32 : 2;
`else
    exp_lat = 2 + 32;
`endif
    start(v);
    wait_rdy(lat);
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (lat < 0) return;
`ifdef BCD2BIN_CHECK_EN
    if (!ok) begin
      check_val({tag, "_bin"}, 32'(bin_d_out), 32'd0);
      check_val({tag, "_ovf"}, 32'(ovf), 32'd0);
      check_val({tag, "_err"}, 32'(err), 32'd1);
    end
`endif
    if (ok) begin
      check_val({tag, "_bin"}, 32'(bin_d_out), 32'(val % 4096));
      check_val({tag, "_ovf"}, 32'(ovf), 32'(val >= 4096));
    end
    if (ok) check_val({tag, "_err"}, 32'(err), 32'd0);
`ifndef BCD2BIN_CHECK_EN
    if (!ok) check_val({tag, "_err"}, 32'(err), 32'd0);
`endif
    @(negedge clk);
    check_val({tag, "_rdy_width"}, 32'(rdy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int pulses;
    int lat2;
    logic [15:0] v;
    int loop_vals[9] = '{0, 1, 11, 21, 121, 221, 1221, 2221, 4095};

    // Reset with en asserted
    rst_n    = 1'b0;
    en       = 1'b1;
    bcd_d_in = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_rdy0", 32'(rdy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_rdy1", 32'(rdy), 32'd0);
    check_val("rst_bin", 32'(bin_d_out), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    en    = 1'b0;
    rst_n = 1'b1;

    // Basic conversions and overflow
    run_one(16'h0000, "zero");
    run_one(16'h0001, "one");
    run_one(16'h1234, "b1234");
    run_one(16'h4095, "b4095");
    run_one(16'h4096, "ovf4096");
    run_one(16'h9999, "ovf9999");
    run_one(16'h0010, "ovf_clear");

    // Invalid digit
    run_one(16'h12A4, "invalid");

    // en re-pulsed mid-conversion is ignored
    start(16'h0500);
    lat = -1;
    pulses = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 10) en = 1'b1;
      if (n == 11) en = 1'b0;
      if (rdy) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          check_val("repulse_bin", 32'(bin_d_out), 32'h1F4);
        end
      end
    end
    check_val("repulse_lat", 32'(lat), 32'd34);
    check_val("repulse_pulses", 32'(pulses), 32'd1);

    // Reset mid-conversion abandons it
    start(16'h0500);
    pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 10) rst_n = 1'b0;
      if (n == 11) rst_n = 1'b1;
      if (rdy) pulses++;
    end
    check_val("midrst_pulses", 32'(pulses), 32'd0);
    check_val("midrst_bin", 32'(bin_d_out), 32'd0);
    check_val("midrst_ovf", 32'(ovf), 32'd0);
    run_one(16'h0777, "after_rst");

    // en held high restarts on every return to IDLE
    @(negedge clk);
    bcd_d_in = 16'h0042;
    en       = 1'b1;
    @(posedge clk);
    lat = -1;
    lat2 = -1;
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      if (rdy) begin
        if (lat < 0) lat = n;
        else if (lat2 < 0) lat2 = n;
      end
      if (n == 75) en = 1'b0;
    end
    check_val("hold_first", 32'(lat), 32'd34);
    check_val("hold_second", 32'(lat2), 32'd69);
    wait_rdy(lat);
    check_val("hold_third_bin", 32'(bin_d_out), 32'd42);

    // Random valid BCD values
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      run_one(v, "rand");
    end

    // Loopback through a binary-to-BCD model
    foreach (loop_vals[i]) run_one(bin_to_bcd(loop_vals[i]), "loop");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
